activation_stream: RTL and testbench
====================================

Name: activation_stream

Overview:
- Streaming, parametrised successor to the fixed 2×28×28 combinational ReLU layer.
- Accepts one beat per handshake; each beat carries one pixel position across CHANNELS feature maps.
- Applies a run-time-selectable activation (bypass, ReLU, clamped ReLU, leaky ReLU) through one registered output stage with valid/ready flow control.
- Tracks frame boundaries and per-frame negative-element statistics. Sits between a conv/accumulate stage and the pooling stage.

Parameters:
- BITWIDTH, 32, width of one signed two's-complement element.
- CHANNELS, 2, number of elements per beat (one per feature map).
- FRAME_LEN, 784, beats per frame (28×28 default); must be ≥2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- mode  input  2  activation: 00 bypass, 01 ReLU, 10 clamped ReLU, 11 leaky ReLU.
- clamp_max  input  BITWIDTH  upper clamp for mode 10; signed, must be ≥0.
- leaky_shift  input  5  arithmetic right-shift amount for negative inputs in mode 11.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat.
- in_data  input  CHANNELS*BITWIDTH  channel c at bits [c*BITWIDTH +: BITWIDTH].
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  CHANNELS*BITWIDTH  activated elements; same packing as in_data.
- out_last  output  1  out_data is the final beat of a frame.
- frame_done  output  1  one-cycle pulse after the last beat of a frame is accepted downstream.
- neg_count  output  $clog2(CHANNELS*FRAME_LEN+1)  count of negative input elements in the most recently completed frame.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_data=0, out_last=0, frame_done=0, neg_count=0, element counter=0, latched mode/clamp/shift=0 (bypass). in_ready=1 once rst_n is released. Reset mid-frame discards the partial frame and its statistics.
- Handshakes: input transfer when in_valid&&in_ready; output transfer when out_valid&&out_ready.
- in_ready = !out_valid || out_ready (combinational; no bubble at full throughput).
- out_valid/out_data/out_last are held stable while out_valid&&!out_ready.
- Latency: a beat accepted in cycle N appears on out_data in cycle N+1. Throughput is 1 beat/cycle.
- Per-frame config: mode, clamp_max and leaky_shift are sampled on the input handshake when the element counter is 0. They are held for the whole frame; changes mid-frame take effect at the next frame.
- Per-element function, x signed, using the latched config:
  - Bypass: y=x.
  - ReLU: y = x<0 ? 0 : x.
  - Clamped ReLU: y = x<0 ? 0 : (x>clamp_max ? clamp_max : x), signed compare.
  - Leaky ReLU: y = x<0 ? (x>>>leaky_shift) : x. Arithmetic shift, so sign is preserved; shift ≥BITWIDTH gives -1 for negative x. No saturation is needed: the result width equals BITWIDTH.
  - Most-negative value (1 followed by zeros) is treated as negative in all modes.
- Element counter: 0..FRAME_LEN-1, increments on each input handshake and wraps to 0 after FRAME_LEN-1. out_last is registered alongside data; it is 1 when the counter was FRAME_LEN-1 at acceptance.
- Statistics:
  - A frame accumulator adds the number of negative channels (0..CHANNELS) in each accepted beat; the sign is evaluated before activation, in every mode including bypass.
  - On the input handshake of the last beat, neg_count ← accumulator + that beat's negatives, and the accumulator ← 0. The first beat of the next frame may arrive in the following cycle without loss.
- frame_done: asserted for exactly one cycle, the cycle after an output handshake with out_last=1.
- Simultaneous input and output handshake in one cycle: the output register loads the new beat (no drop, no duplicate).
- Input accepted only when in_ready=1; in_valid while in_ready=0 has no effect.

Test Plan:
- ReLU, CHANNELS=2, beats {-5,7},{0,-1} with out_ready=1 → outputs {0,7},{0,0} one cycle after each accept; out_valid=1 only in those cycles.
- Clamped, clamp_max=6: beats {9,-3},{6,4} → {6,0},{6,4}. Leaky with leaky_shift=2: {-8,-1} → {-2,-1}. Leaky with shift=31: {-8,5} → {-1,5}.
- Backpressure: out_ready=0 for 3 cycles after first output → out_data held, in_ready=0, no beat lost. Streaming 10 beats with out_ready toggling 1/0 → 10 outputs in order.
- FRAME_LEN=4, full frame of 4 beats each {-1,2} in bypass → out_last on 4th output, frame_done pulse one cycle after its acceptance, neg_count=4. Next frame of all-positive beats → neg_count=0.
- Mode change mid-frame: mode 01→00 after beat 1 of a 4-beat frame → beats 2–4 still ReLU; first beat of the next frame uses bypass.
- Assert rst_n=0 asynchronously mid-frame with out_valid=1 → out_valid, neg_count and counter clear immediately. The next frame's out_last lands on its FRAME_LEN-th beat.

Source files
------------

// File: rtl/activation_stream.sv
// Streaming per-channel activation stage (bypass/ReLU/clamped ReLU/leaky ReLU)
// with one registered output slot, frame tracking and per-frame negative counts.
module activation_stream #(
    parameter int unsigned BITWIDTH  = 32,
    parameter int unsigned CHANNELS  = 2,
    parameter int unsigned FRAME_LEN = 784
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic [1:0]                                 mode,
    input  logic [BITWIDTH-1:0]                        clamp_max,
    input  logic [4:0]                                 leaky_shift,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic [CHANNELS*BITWIDTH-1:0]               in_data,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [CHANNELS*BITWIDTH-1:0]               out_data,
    output logic                                       out_last,
    output logic                                       frame_done,
    output logic [$clog2(CHANNELS*FRAME_LEN+1)-1:0]    neg_count
);

    localparam int unsigned DATA_W = CHANNELS * BITWIDTH;
    localparam int unsigned CNT_W  = $clog2(FRAME_LEN);
    localparam int unsigned NEG_W  = $clog2(CHANNELS * FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'b00,
        MODE_RELU   = 2'b01,
        MODE_CLAMP  = 2'b10,
        MODE_LEAKY  = 2'b11
    } mode_e;

    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [NEG_W-1:0]           acc_q, acc_d;
    logic [NEG_W-1:0]           neg_count_q, neg_count_d;
    mode_e                      mode_q, mode_d;
    logic [BITWIDTH-1:0]        clamp_q, clamp_d;
    logic [4:0]                 shift_q, shift_d;
    logic                       out_valid_q, out_valid_d;
    logic [DATA_W-1:0]          out_data_q, out_data_d;
    logic                       out_last_q, out_last_d;
    logic                       frame_done_q, frame_done_d;

    logic                       in_fire, out_fire, frame_start, frame_end;
    mode_e                      eff_mode;
    logic signed [BITWIDTH-1:0] eff_clamp;
    logic [4:0]                 eff_shift;
    logic [CHANNELS-1:0]        neg_vec;
    logic [DATA_W-1:0]          act_data;
    logic [NEG_W-1:0]           beat_neg;

    assign in_ready    = !out_valid_q || out_ready;
    assign in_fire     = in_valid && in_ready;
    assign out_fire    = out_valid_q && out_ready;
    assign frame_start = (cnt_q == '0);
    assign frame_end   = (cnt_q == LAST_IDX);

    // The first beat of a frame uses the live config, which is latched for the rest.
    assign eff_mode  = frame_start ? mode_e'(mode) : mode_q;
    assign eff_clamp = frame_start ? clamp_max     : clamp_q;
    assign eff_shift = frame_start ? leaky_shift   : shift_q;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic signed [BITWIDTH-1:0] x;
        logic signed [BITWIDTH-1:0] y;

        assign x          = in_data[c*BITWIDTH +: BITWIDTH];
        assign neg_vec[c] = x[BITWIDTH-1];

        always_comb begin
            y = x;
            case (eff_mode)
                MODE_RELU:  if (neg_vec[c]) y = '0;
                MODE_CLAMP: begin
                    if (neg_vec[c])          y = '0;
                    else if (x > eff_clamp)  y = eff_clamp;
                end
                MODE_LEAKY: if (neg_vec[c]) y = x >>> eff_shift;
                default:    y = x;
            endcase
        end

        assign act_data[c*BITWIDTH +: BITWIDTH] = y;
    end

    always_comb begin
        beat_neg = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            beat_neg = beat_neg + NEG_W'(neg_vec[c]);
        end
    end

    // Next-state: an input beat always wins the output slot, even when it drains this cycle.
    always_comb begin
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        neg_count_d  = neg_count_q;
        mode_d       = mode_q;
        clamp_d      = clamp_q;
        shift_d      = shift_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        frame_done_d = out_fire && out_last_q;

        if (out_fire) begin
            out_valid_d = 1'b0;
        end

        if (in_fire) begin
            out_valid_d = 1'b1;
            out_data_d  = act_data;
            out_last_d  = frame_end;
            if (frame_start) begin
                mode_d  = eff_mode;
                clamp_d = eff_clamp;
                shift_d = eff_shift;
            end
            if (frame_end) begin
                cnt_d       = '0;
                acc_d       = '0;
                neg_count_d = acc_q + beat_neg;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                acc_d = acc_q + beat_neg;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            acc_q        <= '0;
            neg_count_q  <= '0;
            mode_q       <= MODE_BYPASS;
            clamp_q      <= '0;
            shift_q      <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            neg_count_q  <= neg_count_d;
            mode_q       <= mode_d;
            clamp_q      <= clamp_d;
            shift_q      <= shift_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign frame_done = frame_done_q;
    assign neg_count  = neg_count_q;

endmodule

// File: tb/tb_activation_stream.sv
// Bench for activation_stream: directed frames plus randomized traffic against a
// transaction-level model of the activation, framing and statistics rules.
module tb_activation_stream;

    localparam int unsigned BW = 32;
    localparam int unsigned CH = 2;
    localparam int unsigned FL = 4;
    localparam int unsigned NW = $clog2(CH * FL + 1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        mode;
    logic [BW-1:0]     clamp_max;
    logic [4:0]        leaky_shift;
    logic              in_valid;
    logic              in_ready;
    logic [CH*BW-1:0]  in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CH*BW-1:0]  out_data;
    logic              out_last;
    logic              frame_done;
    logic [NW-1:0]     neg_count;

    activation_stream #(.BITWIDTH(BW), .CHANNELS(CH), .FRAME_LEN(FL)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .clamp_max(clamp_max),
        .leaky_shift(leaky_shift), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .frame_done(frame_done),
        .neg_count(neg_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CH*BW-1:0] data;
        logic             last;
    } beat_t;

    // reference model state
    beat_t            q[$];
    logic [63:0]      outs[$];
    int               pos, acc, exp_neg;
    logic             exp_fd;
    logic [1:0]       cfg_mode;
    longint           cfg_clamp;
    int               cfg_shift;
    logic             accepted, toggle;
    int               n_vec, n_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pk(input int c0, input int c1);
        return {32'(c1), 32'(c0)};
    endfunction

    // spec-level activation: leaky is floor(x / 2^shift) for negative x
    function automatic logic [BW-1:0] act(input longint x, input logic [1:0] m,
                                          input longint cl, input int sh);
        longint y, p;
        y = x;
        if (x < 0) begin
            if (m == 2'd1 || m == 2'd2) y = 0;
            else if (m == 2'd3) begin
                p = longint'(1) << sh;
                y = x / p;
                if (y * p != x) y = y - 1;
            end
        end else if (m == 2'd2 && x > cl) begin
            y = cl;
        end
        return y[BW-1:0];
    endfunction

    function automatic logic [BW-1:0] rnd_elem();
        int v;
        case ($urandom_range(0, 3))
            0:       begin v = int'($urandom_range(0, 40)) - 20; return 32'(v); end
            1:       return $urandom;
            2:       return 32'h8000_0000;
            default: return 32'h7fff_ffff;
        endcase
    endfunction

    task automatic model_accept();
        beat_t  b;
        longint x;
        int     negs;
        if (pos == 0) begin
            cfg_mode  = mode;
            cfg_clamp = longint'($signed(clamp_max));
            cfg_shift = int'(leaky_shift);
        end
        negs = 0;
        for (int c = 0; c < int'(CH); c++) begin
            x = longint'($signed(in_data[c*BW +: BW]));
            if (x < 0) negs++;
            b.data[c*BW +: BW] = act(x, cfg_mode, cfg_clamp, cfg_shift);
        end
        acc += negs;
        b.last = (pos == int'(FL) - 1);
        if (b.last) begin
            exp_neg = acc;
            acc     = 0;
            pos     = 0;
        end else begin
            pos++;
        end
        q.push_back(b);
    endtask

    task automatic model_reset();
        q.delete();
        pos = 0; acc = 0; exp_neg = 0; exp_fd = 1'b0;
        cfg_mode = 2'd0; cfg_clamp = 0; cfg_shift = 0;
    endtask

    // one clock: check at negedge, advance the model, return at posedge+1
    task automatic cycle();
        logic exp_ir, hs_in, hs_out, fd_n;
        @(negedge clk);
        exp_ir = (q.size() == 0) || out_ready;
        chk("in_ready", 64'(in_ready), 64'(exp_ir));
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            chk("out_data", out_data, q[0].data);
            chk("out_last", 64'(out_last), 64'(q[0].last));
        end
        chk("frame_done", 64'(frame_done), 64'(exp_fd));
        chk("neg_count", 64'(neg_count), 64'(exp_neg));
        hs_in  = in_valid && exp_ir;
        hs_out = (q.size() != 0) && out_ready;
        fd_n   = hs_out && q[0].last;
        if (hs_out) begin
            outs.push_back(out_data);
            void'(q.pop_front());
        end
        if (hs_in) model_accept();
        exp_fd   = fd_n;
        accepted = hs_in;
        @(posedge clk);
        #1;
        if (toggle) out_ready = !out_ready;
    endtask

    task automatic send(input logic [63:0] d);
        int n;
        in_data  = d;
        in_valid = 1'b1;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!accepted && n < 20);
        if (!accepted) chk("send_timeout", 64'(0), 64'(1));
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, n_acc;
        n_vec = 0; n_err = 0; toggle = 1'b0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
        mode = 2'd0; clamp_max = '0; leaky_shift = '0;
        model_reset();

        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", out_data, 64'(0));
        chk("rst_out_last", 64'(out_last), 64'(0));
        chk("rst_frame_done", 64'(frame_done), 64'(0));
        chk("rst_neg_count", 64'(neg_count), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ReLU frame
        mode = 2'd1;
        send(pk(-5, 7)); send(pk(0, -1)); send(pk(3, -2)); send(pk(1, 1));
        idle(2);
        chk("relu_b0", outs[0], pk(0, 7));
        chk("relu_b1", outs[1], pk(0, 0));

        // clamped ReLU frame
        mode = 2'd2; clamp_max = 32'd6;
        send(pk(9, -3)); send(pk(6, 4)); send(pk(-1, 100)); send(pk(int'(32'h8000_0000), 7));
        idle(2);
        chk("clamp_b0", outs[4], pk(6, 0));
        chk("clamp_b1", outs[5], pk(6, 4));

        // leaky frames, shift 2 then 31
        mode = 2'd3; leaky_shift = 5'd2;
        send(pk(-8, -1)); send(pk(-7, 9)); send(pk(-3, 0)); send(pk(int'(32'h8000_0000), -4));
        leaky_shift = 5'd31;
        send(pk(-8, 5)); send(pk(-1, int'(32'h8000_0000))); send(pk(2, -100)); send(pk(0, 0));
        idle(2);
        chk("leaky2_b0", outs[8], pk(-2, -1));
        chk("leaky31_b0", outs[12], pk(-1, 5));

        // backpressure: output stalls 3 cycles while next beat is offered
        mode = 2'd0;
        send(pk(11, -12));
        out_ready = 1'b0; in_data = pk(13, 14); in_valid = 1'b1;
        repeat (3) cycle();
        out_ready = 1'b1;
        send(pk(13, 14)); send(pk(15, 16)); send(pk(-17, 18));
        idle(2);

        // streaming with out_ready toggling every cycle
        toggle = 1'b1;
        for (int i = 0; i < 12; i++) send({rnd_elem(), rnd_elem()});
        in_valid = 1'b0;
        toggle = 1'b0; out_ready = 1'b1;
        idle(3);

        // bypass frame of {-1,2}, then an all-positive frame
        mode = 2'd0;
        repeat (4) send(pk(-1, 2));
        idle(2);
        chk("neg_frame", 64'(neg_count), 64'(4));
        repeat (4) send(pk(5, 6));
        idle(2);
        chk("pos_frame", 64'(neg_count), 64'(0));

        // randomized traffic: 40 beats (whole frames)
        n_acc = 0;
        for (int i = 0; i < 400 && n_acc < 40; i++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            out_ready   = ($urandom_range(0, 3) != 0);
            mode        = 2'($urandom_range(0, 3));
            clamp_max   = 32'($urandom_range(0, 50));
            leaky_shift = 5'($urandom_range(0, 31));
            in_data     = {rnd_elem(), rnd_elem()};
            cycle();
            if (accepted) n_acc++;
        end
        chk("rand_beats", 64'(n_acc), 64'(40));
        out_ready = 1'b1;
        idle(3);

        // mode change mid-frame only affects the next frame
        base = outs.size();
        mode = 2'd1;
        send(pk(-3, -4));
        mode = 2'd0;
        send(pk(-5, 6)); send(pk(-1, -1)); send(pk(-1, -1));
        send(pk(-7, 2)); send(pk(-2, -2)); send(pk(-2, -2)); send(pk(-2, -2));
        idle(2);
        chk("modechg_b1", outs[base + 1], pk(0, 6));
        chk("modechg_next", outs[base + 4], pk(-7, 2));
        chk("modechg_negs", 64'(neg_count), 64'(7));

        // async reset mid-frame while out_valid is held
        out_ready = 1'b0;
        send(pk(-9, -9));
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'(0));
        chk("arst_neg_count", 64'(neg_count), 64'(0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1; mode = 2'd0;
        @(posedge clk); #1;
        base = outs.size();
        send(pk(1, -1)); send(pk(2, -2)); send(pk(3, -3)); send(pk(4, -4));
        idle(3);
        chk("post_rst_outs", 64'(outs.size() - base), 64'(4));
        chk("post_rst_negs", 64'(neg_count), 64'(4));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
